// File: rtl/trap_pkg.sv
// trap_pkg: shared trap encodings, CSR addresses and cause codes
package trap_pkg;
  localparam int PC_W = 15;
  localparam logic [PC_W-1:0] TRAP_VECTOR = 15'h0100;
  localparam logic [11:0] CSR_SEPC = 12'h141;
  localparam logic [11:0] CSR_STVEC = 12'h105;
  localparam logic [63:0] CAUSE_ILLEGAL_INSN = 64'd2;
  localparam logic [63:0] CAUSE_LOAD_FAULT = 64'd5;
  typedef enum logic [2:0] {IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT} state_t;
endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if: exception/CSR inputs and flush/redirect/CSR outputs of the trap path
interface trap_controller_if;
  import trap_pkg::*;
  logic exception;
  logic [PC_W-1:0] sepc;
  logic [63:0] scause;
  logic sret;
  logic csr_we;
  logic [11:0] csr_addr;
  logic [PC_W-1:0] csr_wdata;
  logic flush;
  logic pc_redirect;
  logic [PC_W-1:0] redirect_pc;
  logic in_trap;
  logic halted;
  logic [PC_W-1:0] sepc_q;
  logic [63:0] scause_q;
  logic [PC_W-1:0] stvec_q;
  modport master (
    output exception, sepc, scause, sret, csr_we, csr_addr, csr_wdata,
    input flush, pc_redirect, redirect_pc, in_trap, halted, sepc_q, scause_q, stvec_q
  );
  modport slave (
    input exception, sepc, scause, sret, csr_we, csr_addr, csr_wdata,
    output flush, pc_redirect, redirect_pc, in_trap, halted, sepc_q, scause_q, stvec_q
  );
endinterface

// File: rtl/trap_csr_file.sv
// trap_csr_file: supervisor trap CSRs with fault capture and aligned software writes
module trap_csr_file
  import trap_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic            latch,
  input  logic [11:0]     addr,
  input  logic [PC_W-1:0] wdata,
  input  logic [PC_W-1:0] epc,
  input  logic [63:0]     cause,
  output logic [PC_W-1:0] sepc_q,
  output logic [63:0]     scause_q,
  output logic [PC_W-1:0] stvec_q
);
  logic [PC_W-1:0] aligned;
  assign aligned = {wdata[PC_W-1:2], 2'b00};
  // fault capture wins over a software sepc write in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sepc_q <= '0;
      scause_q <= '0;
      stvec_q <= TRAP_VECTOR;
    end else begin
      if (latch) begin
        sepc_q <= epc;
        scause_q <= cause;
      end else if (we && addr == CSR_SEPC) sepc_q <= aligned;
      if (we && addr == CSR_STVEC) stvec_q <= aligned;
    end
  end
endmodule

// File: rtl/trap_controller.sv
// trap_controller: commits exceptions, flushes and redirects to the handler, returns on sret
module trap_controller
  import trap_pkg::*;
(
  input logic clk,
  input logic rst_n,
  trap_controller_if.slave bus
);
  state_t state, state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = bus.exception ? FLUSH : IDLE;
      FLUSH:    state_nx = REDIRECT;
      REDIRECT: state_nx = HANDLER;
      HANDLER:  state_nx = bus.exception ? HALT : bus.sret ? RETURN : HANDLER;
      RETURN:   state_nx = IDLE;
      HALT:     state_nx = HALT;
      default:  state_nx = IDLE;
    endcase
  end
  // outputs decode the state register only, never the inputs
  assign bus.flush = state inside {FLUSH, RETURN, HALT};
  assign bus.pc_redirect = state inside {REDIRECT, RETURN};
  assign bus.redirect_pc = state == REDIRECT ? bus.stvec_q : state == RETURN ? bus.sepc_q : '0;
  assign bus.in_trap = state == HANDLER;
  assign bus.halted = state == HALT;
  trap_csr_file u_csr (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.csr_we && (state == IDLE || state == HANDLER)),
    .latch    (state == IDLE && bus.exception),
    .addr     (bus.csr_addr),
    .wdata    (bus.csr_wdata),
    .epc      (bus.sepc),
    .cause    (bus.scause),
    .sepc_q   (bus.sepc_q),
    .scause_q (bus.scause_q),
    .stvec_q  (bus.stvec_q)
  );
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed trap sequences checked against an event-schedule model
module tb_trap_controller;
  import trap_pkg::*;
  typedef struct packed {
    logic f;
    logic r;
    logic [14:0] pc;
    logic t;
    logic h;
  } out_t;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  out_t q[$];
  int mode;
  logic [14:0] m_sepc, m_stvec;
  logic [63:0] m_scause;
  trap_controller_if bus();
  trap_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  // steady outputs per mode: 0 idle, 1 handler running, 2 halted; queue holds one-shot cycles
  function automatic out_t exp_out();
    if (q.size() != 0) return q[0];
    return mode == 1 ? out_t'({2'b00, 15'h0, 2'b10}) :
           mode == 2 ? out_t'({2'b10, 15'h0, 2'b01}) : out_t'('0);
  endfunction
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      mode = 0;
      m_sepc = '0;
      m_scause = '0;
      m_stvec = 15'h0100;
    end else if (q.size() != 0) void'(q.pop_front());
    else if (mode != 2) begin
      if (bus.csr_we && bus.csr_addr == 12'h141) m_sepc = bus.csr_wdata & ~15'h3;
      if (bus.csr_we && bus.csr_addr == 12'h105) m_stvec = bus.csr_wdata & ~15'h3;
      if (mode == 0 && bus.exception) begin
        m_sepc = bus.sepc;
        m_scause = bus.scause;
        q.push_back(out_t'({2'b10, 15'h0, 2'b00}));
        q.push_back(out_t'({2'b01, m_stvec, 2'b00}));
        mode = 1;
      end else if (mode == 1 && bus.exception) mode = 2;
      else if (mode == 1 && bus.sret) begin
        q.push_back(out_t'({2'b11, m_sepc, 2'b00}));
        mode = 0;
      end
    end
  end
  initial forever begin
    out_t e;
    @(negedge clk);
    e = exp_out();
    chk("cyc_flush", 64'(bus.flush), 64'(e.f));
    chk("cyc_pc_redirect", 64'(bus.pc_redirect), 64'(e.r));
    chk("cyc_redirect_pc", 64'(bus.redirect_pc), 64'(e.pc));
    chk("cyc_in_trap", 64'(bus.in_trap), 64'(e.t));
    chk("cyc_halted", 64'(bus.halted), 64'(e.h));
    chk("cyc_sepc_q", 64'(bus.sepc_q), 64'(m_sepc));
    chk("cyc_scause_q", bus.scause_q, m_scause);
    chk("cyc_stvec_q", 64'(bus.stvec_q), 64'(m_stvec));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ex, input logic [14:0] pc, input logic [63:0] c, input logic sr,
                       input logic we, input logic [11:0] ad, input logic [14:0] wd);
    bus.exception = ex;
    bus.sepc = pc;
    bus.scause = c;
    bus.sret = sr;
    bus.csr_we = we;
    bus.csr_addr = ad;
    bus.csr_wdata = wd;
  endtask
  task automatic idle_in;
    drive(0, 15'h0, 64'h0, 0, 0, 12'h0, 15'h0);
  endtask
  initial begin
    idle_in();
    repeat (3) tick();
    rst_n = 1;
    chk("rst_flush", 64'(bus.flush), 64'h0);
    chk("rst_stvec", 64'(bus.stvec_q), 64'h0100);
    chk("rst_sepc", 64'(bus.sepc_q), 64'h0);
    repeat (10) tick();
    drive(1, 15'h1000, CAUSE_ILLEGAL_INSN, 0, 0, 12'h0, 15'h0);
    tick();
    drive(0, 15'h0, 64'h0, 0, 1, 12'h105, 15'h0777);
    chk("exc_sepc", 64'(bus.sepc_q), 64'h1000);
    chk("exc_scause", bus.scause_q, 64'h2);
    chk("exc_flush", 64'(bus.flush), 64'h1);
    tick();
    idle_in();
    chk("exc_redirect", 64'(bus.pc_redirect), 64'h1);
    chk("exc_redirect_pc", 64'(bus.redirect_pc), 64'h0100);
    tick();
    chk("exc_in_trap", 64'(bus.in_trap), 64'h1);
    drive(0, 15'h0, 64'h0, 0, 1, 12'h141, 15'h1006);
    tick();
    drive(0, 15'h0, 64'h0, 1, 0, 12'h0, 15'h0);
    tick();
    idle_in();
    chk("ret_redirect_pc", 64'(bus.redirect_pc), 64'h1004);
    chk("ret_sepc", 64'(bus.sepc_q), 64'h1004);
    chk("ret_flush", 64'(bus.flush), 64'h1);
    tick();
    chk("ret_in_trap", 64'(bus.in_trap), 64'h0);
    drive(0, 15'h0, 64'h0, 0, 1, 12'h105, 15'h0200);
    tick();
    drive(0, 15'h0, 64'h0, 1, 1, 12'h123, 15'h7fff);
    tick();
    idle_in();
    chk("stvec_new", 64'(bus.stvec_q), 64'h0200);
    drive(1, 15'h2000, 64'h3, 0, 0, 12'h0, 15'h0);
    tick();
    idle_in();
    tick();
    chk("stvec_redirect_pc", 64'(bus.redirect_pc), 64'h0200);
    tick();
    drive(0, 15'h0, 64'h0, 1, 1, 12'h141, 15'h3009);
    tick();
    idle_in();
    chk("wr_sret_pc", 64'(bus.redirect_pc), 64'h3008);
    tick();
    drive(1, 15'h1000, CAUSE_ILLEGAL_INSN, 0, 0, 12'h0, 15'h0);
    tick();
    idle_in();
    repeat (2) tick();
    drive(1, 15'h4000, CAUSE_LOAD_FAULT, 1, 0, 12'h0, 15'h0);
    tick();
    drive(0, 15'h0, 64'h0, 1, 0, 12'h0, 15'h0);
    chk("dbl_halted", 64'(bus.halted), 64'h1);
    chk("dbl_scause", bus.scause_q, 64'h2);
    repeat (3) tick();
    idle_in();
    chk("halt_hold", 64'(bus.halted), 64'h1);
    chk("halt_flush", 64'(bus.flush), 64'h1);
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    drive(0, 15'h0, 64'h0, 0, 1, 12'h105, 15'h0300);
    tick();
    drive(1, 15'h5000, 64'h7, 0, 0, 12'h0, 15'h0);
    tick();
    idle_in();
    tick();
    chk("mid_redirect", 64'(bus.redirect_pc), 64'h0300);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_redirect", 64'(bus.pc_redirect), 64'h0);
    chk("mid_rst_stvec", 64'(bus.stvec_q), 64'h0100);
    chk("mid_rst_sepc", 64'(bus.sepc_q), 64'h0);
    chk("mid_rst_scause", bus.scause_q, 64'h0);
    tick();
    rst_n = 1;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
# trap_controller

Responder side of the exception path: consumes the `exception`/`sepc`/`scause` triple raised by the combinational exception handler, commits it into supervisor CSRs, flushes the pipeline and redirects fetch to the trap vector. Tracks handler execution, returns to the saved PC on `sret`, and halts the core on a fault taken inside the handler. Sits between the exception handler (EXE stage) and the IF-stage PC mux / pipeline-register flush controls.

## Interface
- `TRAP_VECTOR`, 15'h0100, reset value of `stvec_q` (word-aligned).
- `PC_W`, 15, PC / address width.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `exception`  in  1  level, exception detected this cycle.
- `sepc`  in  PC_W  PC of the faulting instruction.
- `scause`  in  64  cause code; bit 63 = interrupt flag.
- `sret`  in  1  `sret` decoded in EXE, valid this cycle.
- `csr_we`  in  1  CSR write strobe from EXE.
- `csr_addr`  in  12  CSR address (12'h141 sepc, 12'h105 stvec).
- `csr_wdata`  in  PC_W  CSR write data.
- `flush`  out  1  clear IF/ID, ID/EXE, EXE/MEM registers.
- `pc_redirect`  out  1  select `redirect_pc` at the PC mux.
- `redirect_pc`  out  PC_W  next fetch address.
- `in_trap`  out  1  handler is executing.
- `halted`  out  1  double fault, core frozen.
- `sepc_q`  out  PC_W  committed sepc CSR.
- `scause_q`  out  64  committed scause CSR.
- `stvec_q`  out  PC_W  trap vector CSR.

## Operation
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT.
- IDLE: `exception`=1 -> latch `sepc`→`sepc_q`, `scause`→`scause_q`; go FLUSH. `sret` in IDLE ignored.
- FLUSH: `flush`=1 one cycle; inputs ignored; go REDIRECT.
- REDIRECT: `pc_redirect`=1, `redirect_pc`=`stvec_q`; go HANDLER.
- HANDLER: `in_trap`=1. `exception`=1 -> HALT (overrides `sret`; `sepc_q`/`scause_q` keep first fault). Else `sret`=1 -> RETURN.
- RETURN: `flush`=1, `pc_redirect`=1, `redirect_pc`=`sepc_q`; go IDLE.
- HALT: `halted`=1, `flush`=1 held; exit only via reset.
- CSR writes: accepted in IDLE and HANDLER only; low 2 bits of written data forced to 0; unknown addresses ignored. `scause_q` is read-only from software. Write to `sepc` in the same cycle as `sret` is applied first (RETURN uses new value).
- All outputs not listed for a state are 0 in that state.

## Timing
- Reset: state IDLE; `flush`, `pc_redirect`, `in_trap`, `halted` = 0; `redirect_pc` = 0; `sepc_q` = 0; `scause_q` = 0; `stvec_q` = `TRAP_VECTOR`.
- Exception sampled at edge N -> `flush` high cycle N+1, `pc_redirect` high cycle N+2, `in_trap` high from N+3.
- `sret` sampled at edge M -> `flush`+`pc_redirect` high cycle M+1, `in_trap` low from M+1.
- `exception` held high across FLUSH/REDIRECT is not re-taken; held into HANDLER is a double fault (exception handler must deassert once flushed).
- Reset asserted mid-sequence: immediate return to reset values, no partial redirect.
- All outputs registered from state; no combinational input-to-output path.

## Structure
- Shared package `trap_pkg`: state encoding enum, CSR addresses (`CSR_SEPC`, `CSR_STVEC`), `TRAP_VECTOR` default, cause constants matching the exception handler's `scause` codes.
- One sub-module `trap_csr_file`: holds `sepc_q`/`scause_q`/`stvec_q`, write decode and alignment; FSM in top.

## Test plan
- Reset -> all outputs 0, `stvec_q`=15'h0100; 10 idle cycles, no flush.
- `exception`=1, `sepc`=15'h1000, `scause`=64'h2 one cycle -> `sepc_q`=15'h1000, `scause_q`=2, `flush` next cycle, `redirect_pc`=15'h0100 cycle after, `in_trap`=1.
- In HANDLER write `csr_addr`=12'h141, `csr_wdata`=15'h1006, then `sret` -> `sepc_q`=15'h1004 (aligned), `redirect_pc`=15'h1004, back to IDLE.
- Write `stvec`=15'h0200 in IDLE, then exception -> `redirect_pc`=15'h0200.
- Exception with `scause`=5 while in HANDLER (first `scause`=2) -> `halted`=1, `scause_q` stays 2, further `sret` ignored until reset.
- Assert `rst_n`=0 during REDIRECT -> `pc_redirect` drops immediately, all CSRs at reset values.
